// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  // Receive FSM states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // Supported oversampling ratios.
  localparam int PRESCALE_X8  = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;

  // The sampler's registered majority bit is stable this many edges past mid-bit.
  localparam int CHK_OFFSET = 2;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receive path.
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_bit_clr,
  input  logic                  i_bit_en,
  input  logic [PRESCALE_W-1:0] i_last,
  output logic [PRESCALE_W-1:0] o_edge_cnt,
  output logic [3:0]            o_bit_cnt,
  output logic                  o_wrap
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  w_wrap;

  assign w_wrap     = i_en && (r_edge_cnt == i_last);
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_wrap     = w_wrap;

  // Edge counter runs while enabled and wraps at the last oversample; bit counter steps on each wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_en) begin
      r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + PRESCALE_W'(1);
      if (i_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (i_bit_en && w_wrap) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, bit sequencing, checker enables and frame qualification.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  STRT_GLITCH,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  output logic [PRESCALE_W-1:0] EDGE_CNT,
  output logic [3:0]            BIT_CNT,
  output logic                  DAT_SAMP_EN,
  output logic                  STRT_CHK_EN,
  output logic                  DESER_EN,
  output logic                  PAR_CHK_EN,
  output logic                  STP_CHK_EN,
  output logic                  DATA_VALID
);

  rx_state_e             r_state;
  rx_state_e             w_next;
  logic                  r_par_en;
  logic                  r_data_valid;

  logic [PRESCALE_W-1:0] w_last;
  logic [PRESCALE_W-1:0] w_chk;
  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [3:0]            w_bit_cnt;
  logic                  w_wrap;
  logic                  w_at_chk;
  logic                  w_last_bit;
  logic                  w_cnt_en;
  logic                  w_cnt_clr;
  logic                  w_bit_clr;
  logic                  w_bit_en;
  logic                  w_strt_chk_en;
  logic                  w_deser_en;
  logic                  w_par_chk_en;
  logic                  w_stp_chk_en;
  logic                  w_frame_good;

  assign w_last     = PRESCALE - PRESCALE_W'(1);
  assign w_chk      = (PRESCALE >> 1) + PRESCALE_W'(CHK_OFFSET);
  assign w_at_chk   = (w_edge_cnt == w_chk);
  assign w_last_bit = (w_bit_cnt == 4'(DATA_WIDTH - 1));
  assign w_cnt_en   = (r_state != S_IDLE);
  assign w_cnt_clr  = (r_state == S_IDLE);
  assign w_bit_en   = (r_state == S_DATA);

  // Parity errors only count when the frame was started with parity enabled.
  assign w_frame_good = !STP_ERR && !(r_par_en && PAR_ERR);

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_counter (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (w_cnt_en),
    .i_clr      (w_cnt_clr),
    .i_bit_clr  (w_bit_clr),
    .i_bit_en   (w_bit_en),
    .i_last     (w_last),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_wrap     (w_wrap)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture PAR_EN at frame start and register DATA_VALID on the final STOP edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_en     <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && !RX_IN) begin
        r_par_en <= PAR_EN;
      end
      r_data_valid <= (r_state == S_STOP) && w_wrap && w_frame_good;
    end
  end

  // Next-state and single-cycle enable decode; each enable fires at the check edge of its bit.
  always_comb begin
    w_next        = r_state;
    w_bit_clr     = 1'b0;
    w_strt_chk_en = 1'b0;
    w_deser_en    = 1'b0;
    w_par_chk_en  = 1'b0;
    w_stp_chk_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!RX_IN) begin
          w_next = S_START;
        end
      end
      S_START: begin
        w_strt_chk_en = w_at_chk;
        if (w_wrap) begin
          if (STRT_GLITCH) begin
            w_next = S_IDLE;
          end else begin
            w_next    = S_DATA;
            w_bit_clr = 1'b1;
          end
        end
      end
      S_DATA: begin
        w_deser_en = w_at_chk;
        if (w_wrap && w_last_bit) begin
          w_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_par_chk_en = w_at_chk;
        if (w_wrap) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        w_stp_chk_en = w_at_chk;
        if (w_wrap) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign EDGE_CNT    = w_edge_cnt;
  assign BIT_CNT     = w_bit_cnt;
  assign DAT_SAMP_EN = (r_state != S_IDLE);
  assign STRT_CHK_EN = w_strt_chk_en;
  assign DESER_EN    = w_deser_en;
  assign PAR_CHK_EN  = w_par_chk_en;
  assign STP_CHK_EN  = w_stp_chk_en;
  assign DATA_VALID  = r_data_valid;

endmodule
